// File: rtl/skewed_input_fifo_array_if.sv
// skewed_input_fifo_array_if: loader handshake, array drain and status signals of the skewed input FIFO
//  slave  (the FIFO): in flush/s_valid/s_data/m_en; out s_ready/m_valid/m_data/count/empty/busy
//  master (driver):   mirror image of slave
interface skewed_input_fifo_array_if #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic                   flush, s_valid, s_ready, m_en, empty, busy;
  logic [ROWS*DATA_W-1:0] s_data, m_data;
  logic [ROWS-1:0]        m_valid;
  logic [ADDR_W:0]        count;
  modport master(output flush, s_valid, s_data, m_en, input s_ready, m_valid, m_data, count, empty, busy);
  modport slave(input flush, s_valid, s_data, m_en, output s_ready, m_valid, m_data, count, empty, busy);
endinterface

// File: rtl/skewed_input_fifo_array.sv
// skewed_input_fifo_array: circular vector FIFO draining through a per-row diagonal skew line
//  clk, rst (async, active-high); bus: slave side of skewed_input_fifo_array_if
//  row r of a vector popped at cycle t appears at t+1+r (SKEW_EN=1) or t+1 (SKEW_EN=0)
module skewed_input_fifo_array #(
  parameter int DATA_W  = 16,
  parameter int ROWS    = 32,
  parameter int DEPTH   = 16,
  parameter int SKEW_EN = 1
) (
  input logic clk,
  input logic rst,
  skewed_input_fifo_array_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [ADDR_W:0]        wr_ptr, rd_ptr;
  logic [ROWS*DATA_W-1:0] mem [DEPTH];
  logic [ROWS*DATA_W-1:0] head;
  logic                   full, push, pop;
  logic [ROWS-1:0]        row_busy;
  assign full        = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
  assign bus.count   = wr_ptr - rd_ptr;
  assign bus.empty   = wr_ptr == rd_ptr;
  assign bus.s_ready = !full;
  assign bus.busy    = |row_busy;
  assign push        = bus.s_valid & !full & !bus.flush;
  assign pop         = bus.m_en & !bus.empty & !bus.flush;
  // a non-pop cycle feeds a zero bubble so padding is always 0
  assign head        = pop ? mem[rd_ptr[ADDR_W-1:0]] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (ADDR_W+1)'(push);
      rd_ptr <= rd_ptr + (ADDR_W+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= bus.s_data;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int L = SKEW_EN != 0 ? r + 1 : 1;
    logic [L-1:0]             v;
    logic [L-1:0][DATA_W-1:0] d;
    // shift in at stage 0; the oldest stage L-1 drives the row output
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= '0;
        d <= '0;
      end else if (bus.flush) begin
        v <= '0;
        d <= '0;
      end else begin
        v <= L'({v, pop});
        d <= (L*DATA_W)'({d, head[r*DATA_W +: DATA_W]});
      end
    assign bus.m_valid[r]                  = v[L-1];
    assign bus.m_data[r*DATA_W +: DATA_W]  = d[L-1];
    assign row_busy[r]                     = |v;
  end
endmodule

// File: tb/tb_skewed_input_fifo_array.sv
// tb_skewed_input_fifo_array: randomized and directed checks of the skewed input FIFO against a queue/history model
module tb_skewed_input_fifo_array;
  localparam int DW = 16;
  localparam int RA = 4;
  localparam int DA = 4;
  localparam int RB = 32;
  localparam int DB = 16;
  logic clk = 0;
  logic rst = 1;
  int   vectors = 0;
  int   errors  = 0;
  skewed_input_fifo_array_if #(.DATA_W(DW), .ROWS(RA), .DEPTH(DA)) ai();
  skewed_input_fifo_array_if #(.DATA_W(DW), .ROWS(RB), .DEPTH(DB)) bi();
  skewed_input_fifo_array #(.DATA_W(DW), .ROWS(RA), .DEPTH(DA), .SKEW_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ai.slave));
  skewed_input_fifo_array #(.DATA_W(DW), .ROWS(RB), .DEPTH(DB), .SKEW_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(bi.slave));
  always #5 clk = ~clk;

  // model of the ROWS=4 instance: stored vectors, plus what was popped in each of the last 4 cycles
  logic [63:0] fifo [$];
  bit   [3:0]  hv;
  logic [63:0] hd [4];

  task automatic model_clear();
    fifo.delete();
    hv = '0;
    foreach (hd[i]) hd[i] = '0;
  endtask

  // row r now shows whatever was popped r cycles before the most recent edge
  function automatic logic [63:0] e_data();
    logic [63:0] e = '0;
    for (int r = 0; r < RA; r++) if (hv[r]) e[r*16 +: 16] = hd[r][r*16 +: 16];
    return e;
  endfunction

  function automatic logic [RB*DW-1:0] rand_b();
    logic [RB*DW-1:0] x;
    for (int i = 0; i < RB*DW/32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic step_a(input bit sv, input logic [63:0] sd, input bit men, input bit fl);
    bit push, pop;
    ai.s_valid = sv;
    ai.s_data  = sd;
    ai.m_en    = men;
    ai.flush   = fl;
    push = sv && fifo.size() < DA && !fl;
    pop  = men && fifo.size() != 0 && !fl;
    @(posedge clk);
    if (fl) model_clear();
    else begin
      for (int i = 3; i > 0; i--) hd[i] = hd[i-1];
      hv = {hv[2:0], pop};
      hd[0] = '0;
      if (pop) hd[0] = fifo.pop_front();
      if (push) fifo.push_back(sd);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    ai.s_valid = 1'($urandom); ai.s_data = {$urandom, $urandom}; ai.m_en = 1'($urandom); ai.flush = 1'($urandom);
    bi.s_valid = 1'($urandom); bi.s_data = rand_b(); bi.m_en = 1'($urandom); bi.flush = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ai.m_valid !== '0 || ai.m_data !== '0) begin
      errors++; $display("FAIL reset_a_out: valid=%b data=%h, want 0/0", ai.m_valid, ai.m_data);
    end
    vectors++;
    if (ai.count !== '0 || ai.empty !== 1'b1 || ai.s_ready !== 1'b1 || ai.busy !== 1'b0) begin
      errors++; $display("FAIL reset_a_status: count=%0d empty=%b s_ready=%b busy=%b, want 0 1 1 0", ai.count, ai.empty, ai.s_ready, ai.busy);
    end
    vectors++;
    if (bi.m_valid !== '0 || bi.m_data !== '0 || bi.count !== '0 || bi.empty !== 1'b1 || bi.s_ready !== 1'b1 || bi.busy !== 1'b0) begin
      errors++; $display("FAIL reset_b: valid=%h count=%0d empty=%b s_ready=%b busy=%b, want 0 0 1 1 0", bi.m_valid, bi.count, bi.empty, bi.s_ready, bi.busy);
    end
    ai.s_valid = 0; ai.m_en = 0; ai.flush = 0; ai.s_data = '0;
    bi.s_valid = 0; bi.m_en = 0; bi.flush = 0; bi.s_data = '0;
    model_clear();
    rst = 0;
  endtask

  task automatic test_skew();
    logic [3:0] ev;
    step_a(1, {16'd4, 16'd3, 16'd2, 16'd1}, 0, 0);
    vectors++;
    if (ai.count !== 3'd1 || ai.m_valid !== '0) begin
      errors++; $display("FAIL skew_push: count=%0d valid=%b, want 1 0000", ai.count, ai.m_valid);
    end
    step_a(0, '0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      ev = k < 4 ? 4'(1 << k) : 4'd0;
      vectors++;
      if (ai.m_valid !== ev || (k < 4 && ai.m_data[(k%4)*16 +: 16] !== 16'(k+1)) || ai.busy !== (k < 4) || ai.m_data !== e_data()) begin
        errors++; $display("FAIL skew_t%0d: valid=%b data=%h busy=%b, want valid=%b data=%h busy=%b", k+2, ai.m_valid, ai.m_data, ai.busy, ev, e_data(), k < 4);
      end
      step_a(0, '0, 0, 0);
    end
  endtask

  task automatic test_full();
    logic [63:0] d [4];
    foreach (d[i]) begin
      d[i] = {$urandom, $urandom};
      step_a(1, d[i], 0, 0);
    end
    vectors++;
    if (ai.count !== 3'd4 || ai.s_ready !== 1'b0 || ai.empty !== 1'b0) begin
      errors++; $display("FAIL full_state: count=%0d s_ready=%b empty=%b, want 4 0 0", ai.count, ai.s_ready, ai.empty);
    end
    step_a(1, 64'h5555_aaaa_1234_5678, 1, 0);
    vectors++;
    if (ai.count !== 3'd3 || ai.s_ready !== 1'b1 || ai.m_valid[0] !== 1'b1 || ai.m_data[15:0] !== d[0][15:0]) begin
      errors++; $display("FAIL full_no_push: count=%0d s_ready=%b row0=%b/%h, want 3 1 1/%h", ai.count, ai.s_ready, ai.m_valid[0], ai.m_data[15:0], d[0][15:0]);
    end
    step_a(1, 64'h5555_aaaa_1234_5678, 0, 0);
    vectors++;
    if (ai.count !== 3'd4 || ai.m_data !== e_data() || ai.m_valid !== hv) begin
      errors++; $display("FAIL full_retry: count=%0d valid=%b data=%h, want 4 %b %h", ai.count, ai.m_valid, ai.m_data, hv, e_data());
    end
    step_a(0, '0, 0, 1);
  endtask

  task automatic test_wrap();
    step_a(1, {4{16'd0}}, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step_a(1, {4{16'(i+1)}}, 1, 0);
      vectors++;
      if (ai.m_valid[0] !== 1'b1 || ai.m_data[15:0] !== 16'(i) || ai.count !== 3'd1 || ai.m_valid !== hv || ai.m_data !== e_data()) begin
        errors++; $display("FAIL wrap_%0d: row0=%b/%0d count=%0d valid=%b, want 1/%0d 1 %b", i, ai.m_valid[0], ai.m_data[15:0], ai.count, ai.m_valid, i, hv);
      end
    end
    step_a(0, '0, 0, 1);
  endtask

  task automatic test_bubble_flush();
    logic [63:0] d [5];
    logic [2:0]  pat = 3'b101;
    foreach (d[i]) d[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) step_a(1, d[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) step_a(0, '0, 0, 0);
      else step_a(1, d[i+1], 1, 0);
      vectors++;
      if (ai.m_valid[0] !== pat[i] || ai.m_data[15:0] !== (i == 0 ? d[0][15:0] : i == 2 ? d[1][15:0] : 16'd0) || ai.m_valid !== hv || ai.m_data !== e_data()) begin
        errors++; $display("FAIL bubble_%0d: valid=%b data=%h, want %b %h", i, ai.m_valid, ai.m_data, hv, e_data());
      end
    end
    vectors++;
    if (ai.count !== 3'd3 || ai.busy !== 1'b1) begin
      errors++; $display("FAIL preflush: count=%0d busy=%b, want 3 1", ai.count, ai.busy);
    end
    step_a(1, {$urandom, $urandom}, 1, 1);
    vectors++;
    if (ai.count !== '0 || ai.m_valid !== '0 || ai.m_data !== '0 || ai.busy !== 1'b0 || ai.empty !== 1'b1) begin
      errors++; $display("FAIL flush: count=%0d valid=%b data=%h busy=%b empty=%b, want 0 0 0 0 1", ai.count, ai.m_valid, ai.m_data, ai.busy, ai.empty);
    end
    step_a(0, '0, 1, 0);
    vectors++;
    if (ai.count !== '0 || ai.m_valid !== '0) begin
      errors++; $display("FAIL flush_drop: count=%0d valid=%b, want 0 0", ai.count, ai.m_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      step_a(1'($urandom), {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 50) == 0);
      vectors++;
      if (ai.m_valid !== hv || ai.m_data !== e_data() || ai.busy !== (|hv) || ai.count !== 3'(fifo.size()) || ai.empty !== (fifo.size() == 0) || ai.s_ready !== (fifo.size() < DA)) begin
        errors++; $display("FAIL random_%0d: valid=%b data=%h busy=%b count=%0d, want %b %h %b %0d", n, ai.m_valid, ai.m_data, ai.busy, ai.count, hv, e_data(), |hv, fifo.size());
      end
    end
    step_a(0, '0, 0, 1);
  endtask

  task automatic test_noskew();
    logic [RB*DW-1:0] v0 = rand_b();
    logic [RB*DW-1:0] v1 = rand_b();
    bi.s_valid = 1; bi.s_data = v0;
    @(posedge clk); #1;
    bi.s_valid = 0; bi.m_en = 1;
    @(posedge clk); #1;
    bi.m_en = 0;
    vectors++;
    if (bi.m_valid !== '1 || bi.m_data !== v0 || bi.busy !== 1'b1 || bi.count !== '0) begin
      errors++; $display("FAIL noskew_pop: valid=%h busy=%b count=%0d data=%h, want all-ones 1 0 %h", bi.m_valid, bi.busy, bi.count, bi.m_data, v0);
    end
    @(posedge clk); #1;
    vectors++;
    if (bi.m_valid !== '0 || bi.m_data !== '0 || bi.busy !== 1'b0) begin
      errors++; $display("FAIL noskew_once: valid=%h busy=%b, want 0 0", bi.m_valid, bi.busy);
    end
    bi.s_valid = 1; bi.s_data = v1;
    @(posedge clk); #1;
    bi.m_en = 1; bi.s_data = v0;
    @(posedge clk); #1;
    bi.s_valid = 0; bi.m_en = 0;
    vectors++;
    if (bi.m_valid !== '1 || bi.m_data !== v1 || bi.count !== 5'd1) begin
      errors++; $display("FAIL noskew_drain: valid=%h count=%0d, want all-ones 1", bi.m_valid, bi.count);
    end
    #2 rst = 1;
    #1;
    vectors++;
    if (bi.m_valid !== '0 || bi.m_data !== '0 || bi.busy !== 1'b0 || bi.count !== '0 || bi.empty !== 1'b1) begin
      errors++; $display("FAIL async_rst: valid=%h busy=%b count=%0d empty=%b, want 0 0 0 1", bi.m_valid, bi.busy, bi.count, bi.empty);
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    @(posedge clk); #1;
    vectors++;
    if (bi.m_valid !== '0 || bi.busy !== 1'b0 || bi.count !== '0) begin
      errors++; $display("FAIL post_rst: valid=%h busy=%b count=%0d, want 0 0 0", bi.m_valid, bi.busy, bi.count);
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_full();
    test_wrap();
    test_bubble_flush();
    test_random();
    test_noskew();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
